num_splitter: RTL and testbench

NUM_SPLITTER -- requirements
Module: num_splitter

---
 rtl/calc_pkg.sv | 28 ++
 rtl/div10.sv | 16 +
 rtl/num_splitter.sv | 193 +++++++++++++++++++
 tb/tb_num_splitter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared tokens, packed-number field layout and FSM states for num_splitter
package calc_pkg;

    // Non-digit token codes
    localparam logic [7:0] TOK_DOT   = 8'hDD;
    localparam logic [7:0] TOK_MINUS = 8'hE0;

    // Packed number layout: {sign, mantissa, exp}
    localparam int SIGN_BIT = 41;
    localparam int MANT_MSB = 40;
    localparam int MANT_LSB = 7;
    localparam int MANT_W   = MANT_MSB - MANT_LSB + 1;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 0;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

    // A 34-bit mantissa has at most 11 decimal digits
    localparam int SCRATCH_N = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_CHECK,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/div10.sv
// rtl/div10.sv - combinational divide-by-ten with 4-bit remainder
module div10
    import calc_pkg::*;
(
    input  logic [MANT_W-1:0] dividend_i,
    output logic [MANT_W-1:0] quotient_o,
    output logic [3:0]        remainder_o
);

    // Constant divisor, so synthesis reduces this to a fixed arithmetic network
    always_comb begin
        quotient_o  = dividend_i / MANT_W'(10);
        remainder_o = 4'(dividend_i % MANT_W'(10));
    end

endmodule

// File: rtl/num_splitter.sv
// rtl/num_splitter.sv - converts a packed decimal float into a stream of digit/point/minus tokens
module num_splitter
    import calc_pkg::*;
#(
    parameter int depth    = 16,
    parameter int width    = 8,
    parameter int newWidth = 42
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    eval,
    input  logic [newWidth-1:0]     numIn,
    output logic [width-1:0]        memOut [depth],
    output logic [$clog2(depth):0]  newSize,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    localparam int NS_W = $clog2(depth) + 1;

    state_e              state_q;
    logic                eval_prev_q;
    logic [MANT_W-1:0]   mant_q;
    logic [EXP_W-1:0]    exp_q;
    logic                minus_q;
    logic [3:0]          cnt_q;
    logic [3:0]          scratch_q [SCRATCH_N];
    logic [width-1:0]    mem_q [depth];
    logic [NS_W-1:0]     size_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;

    logic                do_eval;
    logic [MANT_W-1:0]   quo;
    logic [3:0]          rem;

    // Digit count, fraction length, token total and the token for the current slot
    logic [7:0]          n_w;
    logic [7:0]          f_w;
    logic [7:0]          body_w;
    logic [7:0]          total_w;
    logic [7:0]          k_w;
    logic [7:0]          j_w;
    logic [7:0]          idx_w;
    logic                use_digit;
    logic [width-1:0]    tok_w;

    assign do_eval = eval & ~eval_prev_q;

    div10 u_div10 (
        .dividend_i  (mant_q),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    // Layout arithmetic and token selection; scratch holds digits LSD first
    always_comb begin
        n_w = {4'd0, cnt_q};
        f_w = exp_q[EXP_W-1] ? (8'd128 - {1'b0, exp_q}) : 8'd0;
        if (!exp_q[EXP_W-1]) begin
            body_w = n_w + {1'b0, exp_q};
        end else if (n_w > f_w) begin
            body_w = n_w + 8'd1;
        end else begin
            body_w = f_w + 8'd2;
        end
        total_w   = body_w + {7'd0, minus_q};
        k_w       = 8'(size_q);
        j_w       = k_w - {7'd0, minus_q};
        use_digit = 1'b0;
        idx_w     = 8'd0;
        tok_w     = '0;
        if (minus_q && k_w == 8'd0) begin
            tok_w = width'(TOK_MINUS);
        end else if (!exp_q[EXP_W-1]) begin
            // Integer: all digits, then the exponent's worth of zeros
            if (j_w < n_w) begin
                use_digit = 1'b1;
                idx_w     = n_w - 8'd1 - j_w;
            end
        end else if (n_w > f_w) begin
            // Point falls inside the digit string
            if (j_w < n_w - f_w) begin
                use_digit = 1'b1;
                idx_w     = n_w - 8'd1 - j_w;
            end else if (j_w == n_w - f_w) begin
                tok_w = width'(TOK_DOT);
            end else begin
                use_digit = 1'b1;
                idx_w     = n_w - j_w;
            end
        end else begin
            // Pure fraction: "0." then leading zeros then all digits
            if (j_w == 8'd1) begin
                tok_w = width'(TOK_DOT);
            end else if (j_w >= f_w - n_w + 8'd2) begin
                use_digit = 1'b1;
                idx_w     = f_w + 8'd1 - j_w;
            end
        end
        if (use_digit && idx_w < 8'(SCRATCH_N)) begin
            tok_w = width'(scratch_q[idx_w[3:0]]);
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            eval_prev_q <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            minus_q     <= 1'b0;
            cnt_q       <= '0;
            size_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < SCRATCH_N; i++) begin
                scratch_q[i] <= '0;
            end
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            eval_prev_q <= eval;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (do_eval) begin
                        mant_q  <= numIn[MANT_MSB:MANT_LSB];
                        exp_q   <= numIn[EXP_MSB:EXP_LSB];
                        minus_q <= numIn[SIGN_BIT] & (|numIn[MANT_MSB:MANT_LSB]);
                        cnt_q   <= '0;
                        size_q  <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        for (int i = 0; i < depth; i++) begin
                            mem_q[i] <= '0;
                        end
                        state_q <= ST_DIGITS;
                    end
                end
                ST_DIGITS: begin
                    scratch_q[cnt_q] <= rem;
                    cnt_q            <= cnt_q + 4'd1;
                    mant_q           <= quo;
                    if (quo == '0) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (int'(total_w) > depth) begin
                        ovf_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    for (int i = 0; i < depth; i++) begin
                        if (size_q == NS_W'(i)) begin
                            mem_q[i] <= tok_w;
                        end
                    end
                    size_q <= size_q + 1'b1;
                    if (k_w + 8'd1 == total_w) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign memOut  = mem_q;
    assign newSize = size_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_num_splitter.sv
// tb/tb_num_splitter.sv - self-checking bench for num_splitter against a token-list reference model
module tb_num_splitter;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        eval;
    logic [41:0] numIn;
    logic [7:0]  memOut [DEPTH];
    logic [4:0]  newSize;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_tok[$];
    int exp_n;
    bit exp_ovf;

    always #5 clock = ~clock;

    num_splitter #(.depth(DEPTH), .width(8), .newWidth(42)) dut (
        .clock   (clock),
        .reset   (reset),
        .eval    (eval),
        .numIn   (numIn),
        .memOut  (memOut),
        .newSize (newSize),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: write the number out as text-like tokens, then count
    task automatic model(input bit s, input longint m, input int e);
        int     d[$];
        longint r;
        int     n;
        int     f;
        exp_tok.delete();
        r = m;
        if (r == 0) d.push_back(0);
        while (r > 0) begin
            d.push_front(int'(r % 10));
            r = r / 10;
        end
        n     = d.size();
        exp_n = n;
        if (e >= 0) begin
            foreach (d[i]) exp_tok.push_back(d[i]);
            repeat (e) exp_tok.push_back(0);
        end else begin
            f = -e;
            if (n > f) begin
                for (int i = 0; i < n; i++) begin
                    if (i == n - f) exp_tok.push_back('hDD);
                    exp_tok.push_back(d[i]);
                end
            end else begin
                exp_tok.push_back(0);
                exp_tok.push_back('hDD);
                repeat (f - n) exp_tok.push_back(0);
                foreach (d[i]) exp_tok.push_back(d[i]);
            end
        end
        if (s && m != 0) exp_tok.push_front('hE0);
        exp_ovf = exp_tok.size() > DEPTH;
    endtask

    task automatic drive(input bit s, input longint m, input int e);
        @(negedge clock);
        numIn = {s, m[33:0], e[6:0]};
        eval  = 1'b1;
    endtask

    // Counts cycles from the doEval cycle; optionally re-pulses eval at cycle pulse_at
    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cyc == 1) begin
                eval = 1'b0;
                chk("busy_after_start", busy, 1);
            end
            if (pulse_at > 0 && cyc == pulse_at) eval = 1'b1;
            if (pulse_at > 0 && cyc == pulse_at + 1) eval = 1'b0;
            if (done) break;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic check_result(input string tag, input int cyc);
        int tt;
        tt = exp_tok.size();
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_cycle"}, cyc, exp_ovf ? exp_n + 2 : exp_n + tt + 2);
        chk({tag, "_newSize"}, newSize, exp_ovf ? 0 : tt);
        chk({tag, "_busy_at_done"}, busy, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_slot%0d", tag, i), memOut[i],
                (!exp_ovf && i < tt) ? exp_tok[i] : 0);
        end
        @(posedge clock);
        #1;
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_newSize_hold"}, newSize, exp_ovf ? 0 : tt);
    endtask

    task automatic conv(input string tag, input bit s, input longint m, input int e);
        int cyc;
        model(s, m, e);
        drive(s, m, e);
        wait_done(0, cyc);
        check_result(tag, cyc);
    endtask

    initial begin
        int     cyc;
        bit     rs;
        longint rm;
        int     re;

        reset = 1'b1;
        eval  = 1'b0;
        numIn = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_newSize", newSize, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", ovf, 0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("reset_slot%0d", i), memOut[i], 0);
        reset = 1'b0;

        conv("pos_frac", 1'b0, 12345, -2);
        conv("neg_small_frac", 1'b1, 5, -3);
        conv("neg_zero", 1'b1, 0, 0);
        conv("ovf_big_exp", 1'b0, 7, 20);
        conv("max_mant", 1'b0, 64'd17179869183, 0);
        conv("exact_depth", 1'b0, 123456, 10);
        conv("frac_equal_n", 1'b1, 987, -3);

        // Second rising edge of eval during EMIT must be ignored
        model(1'b0, 12345, -2);
        drive(1'b0, 12345, -2);
        wait_done(9, cyc);
        check_result("reeval_in_emit", cyc);

        // Reset in the middle of EMIT clears everything on the next cycle
        drive(1'b0, 12345, -2);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) eval = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midreset_newSize", newSize, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_ovf", ovf, 0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("midreset_slot%0d", i), memOut[i], 0);
        conv("after_midreset", 1'b0, 42, -1);

        // eval held high through reset starts a conversion right after reset
        @(negedge clock);
        reset = 1'b1;
        eval  = 1'b1;
        numIn = {1'b1, 34'd906, 7'd1};
        model(1'b1, 906, 1);
        @(negedge clock);
        reset = 1'b0;
        wait_done(0, cyc);
        check_result("eval_through_reset", cyc);

        for (int t = 0; t < 40; t++) begin
            rs = 1'($urandom_range(0, 1));
            rm = ((longint'($urandom) << 32) | longint'($urandom)) & 64'h3_FFFF_FFFF;
            rm = rm >> $urandom_range(0, 33);
            re = int'($urandom_range(0, 26)) - 14;
            conv($sformatf("rand%0d", t), rs, rm, re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
